// File: rtl/pixel_sequencer.sv
// -----------------------------------------------------------------------------
// pixel_sequencer
//
// Walks a rectangular frame in raster order (x fastest, then y) and offers
// each (x, y) coordinate to a downstream compute unit with a valid/ready
// handshake. The unit returns one res_valid pulse per accepted coordinate;
// the sequencer limits coordinates in flight to MAX_OUT. After the last
// coordinate is accepted it drains the remaining results and then pulses
// done for one cycle.
//
// Optional feature macro: PIXEL_SEQ_LOOP_EN
//   defined   : adds input 'loop'. When loop=1 at frame completion the
//               sequencer pulses done and restarts the same frame from (0,0)
//               without a new start.
//   undefined : no 'loop' port; completion always returns to IDLE.
//
// Parameters
//   XW, YW   : coordinate widths
//   MAX_OUT  : maximum accepted coordinates without a returned result (1..255)
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   start             : frame start request (honoured only in IDLE)
//   abort             : synchronous frame abort (ISSUE/DRAIN only)
//   loop              : repeat frame on completion (PIXEL_SEQ_LOOP_EN only)
//   x_max, y_max      : inclusive frame limits, latched on accepted start
//   coord_valid/ready : coordinate handshake, coordinate on x, y
//   res_valid         : one result returned by the compute unit
//   busy              : high while a frame is issuing or draining
//   done              : one-cycle pulse at frame completion
//   err               : sticky, result returned with nothing outstanding
// -----------------------------------------------------------------------------
module pixel_sequencer #(
  parameter int XW      = 10,
  parameter int YW      = 10,
  parameter int MAX_OUT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
`ifdef PIXEL_SEQ_LOOP_EN
  input  logic          loop,
`endif
  input  logic [XW-1:0] x_max,
  input  logic [YW-1:0] y_max,
  output logic          coord_valid,
  input  logic          coord_ready,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  input  logic          res_valid,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam logic [OW-1:0] OUT_LIMIT = OW'(MAX_OUT);
  localparam logic [OW-1:0] OUT_ZERO  = {OW{1'b0}};
  localparam logic [OW-1:0] OUT_ONE   = OW'(1);
  localparam logic [XW-1:0] X_ZERO    = {XW{1'b0}};
  localparam logic [XW-1:0] X_ONE     = XW'(1);
  localparam logic [YW-1:0] Y_ZERO    = {YW{1'b0}};
  localparam logic [YW-1:0] Y_ONE     = YW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [XW-1:0] xlim_q, xlim_d;
  logic [YW-1:0] ylim_q, ylim_d;
  logic [OW-1:0] outst_q, outst_d;
  logic          coord_valid_q, coord_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          xfer_s;
  logic          res_ok_s;
  logic [OW-1:0] outst_cnt_s;

  // Next-state and next-output computation for the whole sequencer.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    xlim_d   = xlim_q;
    ylim_d   = ylim_q;
    outst_d  = outst_q;
    done_d   = 1'b0;
    err_d    = err_q;

    xfer_s   = coord_valid_q & coord_ready;
    // A result is only legal if something is in flight, counting a coordinate
    // accepted in this very cycle.
    res_ok_s = res_valid & ((outst_q != OUT_ZERO) | xfer_s);

    if (xfer_s && !res_ok_s) begin
      outst_cnt_s = outst_q + OUT_ONE;
    end else if (!xfer_s && res_ok_s) begin
      outst_cnt_s = outst_q - OUT_ONE;
    end else begin
      outst_cnt_s = outst_q;
    end

    if (res_valid && !res_ok_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          xlim_d  = x_max;
          ylim_d  = y_max;
          x_d     = X_ZERO;
          y_d     = Y_ZERO;
          outst_d = OUT_ZERO;
          err_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          state_d = S_IDLE;
          outst_d = OUT_ZERO;
        end else begin
          outst_d = outst_cnt_s;
          if (xfer_s) begin
            if (x_q == xlim_q) begin
              // Last pixel: hold x/y on the final coordinate while draining.
              if (y_q == ylim_q) begin
                state_d = S_DRAIN;
              end else begin
                x_d = X_ZERO;
                y_d = y_q + Y_ONE;
              end
            end else begin
              x_d = x_q + X_ONE;
            end
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
          outst_d = OUT_ZERO;
        end else if (outst_q == OUT_ZERO) begin
          done_d = 1'b1;
`ifdef PIXEL_SEQ_LOOP_EN
          if (loop) begin
            state_d = S_ISSUE;
            x_d     = X_ZERO;
            y_d     = Y_ZERO;
            outst_d = OUT_ZERO;
          end else begin
            state_d = S_IDLE;
          end
`else
          state_d = S_IDLE;
`endif
        end else begin
          outst_d = outst_cnt_s;
        end
      end
      default: begin
        state_d = S_IDLE;
        outst_d = OUT_ZERO;
      end
    endcase

    // Outputs are registered, so derive them from the next state.
    coord_valid_d = (state_d == S_ISSUE) && (outst_d < OUT_LIMIT);
    busy_d        = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      x_q           <= X_ZERO;
      y_q           <= Y_ZERO;
      xlim_q        <= X_ZERO;
      ylim_q        <= Y_ZERO;
      outst_q       <= OUT_ZERO;
      coord_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      xlim_q        <= xlim_d;
      ylim_q        <= ylim_d;
      outst_q       <= outst_d;
      coord_valid_q <= coord_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign coord_valid = coord_valid_q;
  assign x           = x_q;
  assign y           = y_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_pixel_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pixel_sequencer
//
// Directed self-checking bench for pixel_sequencer with default parameters
// (XW=10, YW=10, MAX_OUT=8). Inputs change 1 time unit after the rising edge
// and outputs are sampled at the same point. The loop scenario is compiled in
// only when PIXEL_SEQ_LOOP_EN is defined.
// -----------------------------------------------------------------------------
module tb_pixel_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        loop;
  logic [9:0]  x_max;
  logic [9:0]  y_max;
  logic        coord_valid;
  logic        coord_ready;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        res_valid;
  logic        busy;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;

  int          xq[$];
  int          yq[$];
  int          n_done;
  int          stall_bad;
  logic        sh1;
  logic        xf1;
  logic        got_done;

  always #5 clk = ~clk;

  pixel_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
`ifdef PIXEL_SEQ_LOOP_EN
    .loop        (loop),
`endif
    .x_max       (x_max),
    .y_max       (y_max),
    .coord_valid (coord_valid),
    .coord_ready (coord_ready),
    .x           (x),
    .y           (y),
    .res_valid   (res_valid),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  // Count a comparison and report a mismatch.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rec();
    xq.delete();
    yq.delete();
    n_done    = 0;
    stall_bad = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  // Run ncyc cycles, recording transfers, done pulses and stall violations.
  // ready_mode 0: ready always high; 1: ready toggles 1,0,1,0...
  // res_delay 0: no results; N>0: result N cycles after each transfer.
  task automatic run(input int ncyc, input int ready_mode, input int res_delay);
    logic [3:0] sh;
    logic       xf;
    logic       stall;
    logic [9:0] px;
    logic [9:0] py;
    sh = 4'b0000;
    for (int i = 0; i < ncyc; i++) begin
      coord_ready = (ready_mode == 1) ? ((i % 2) == 0) : 1'b1;
      res_valid   = (res_delay > 0) ? sh[res_delay-1] : 1'b0;
      xf    = coord_valid && coord_ready;
      stall = coord_valid && !coord_ready;
      px    = x;
      py    = y;
      if (xf) begin
        xq.push_back(int'(x));
        yq.push_back(int'(y));
      end
      tick();
      if (done) n_done++;
      if (stall && ((x !== px) || (y !== py))) stall_bad++;
      sh = {sh[2:0], xf};
    end
    res_valid   = 1'b0;
    coord_ready = 1'b1;
  endtask

  // Check the recorded coordinates against raster order for a w-wide frame.
  task automatic check_raster(input string tag, input int w);
    for (int i = 0; i < xq.size(); i++) begin
      check_eq($sformatf("%s_x%0d", tag, i), 32'(xq[i]), 32'(i % w));
      check_eq($sformatf("%s_y%0d", tag, i), 32'(yq[i]), 32'(i / w));
    end
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    loop        = 1'b0;
    x_max       = 10'd0;
    y_max       = 10'd0;
    coord_ready = 1'b0;
    res_valid   = 1'b0;
    clear_rec();
    #12;
    check_eq("rst_cv",   32'(coord_valid), 32'd0);
    check_eq("rst_busy", 32'(busy),        32'd0);
    check_eq("rst_done", 32'(done),        32'd0);
    check_eq("rst_err",  32'(err),         32'd0);
    check_eq("rst_x",    32'(x),           32'd0);
    check_eq("rst_y",    32'(y),           32'd0);
    rst = 1'b0;
    tick();

    // 4x2 frame, ready always high, results two cycles after each transfer.
    clear_rec();
    x_max = 10'd3;
    y_max = 10'd1;
    coord_ready = 1'b1;
    pulse_start();
    check_eq("f1_cv_after_start", 32'(coord_valid), 32'd1);
    check_eq("f1_busy",           32'(busy),        32'd1);
    run(40, 0, 2);
    check_eq("f1_count", 32'(xq.size()), 32'd8);
    check_raster("f1", 4);
    check_eq("f1_done",  32'(n_done), 32'd1);
    check_eq("f1_err",   32'(err),    32'd0);
    check_eq("f1_idle",  32'(busy),   32'd0);

    // Single-pixel frame issues exactly one coordinate.
    clear_rec();
    x_max = 10'd0;
    y_max = 10'd0;
    pulse_start();
    run(12, 0, 1);
    check_eq("sp_count", 32'(xq.size()), 32'd1);
    check_raster("sp", 1);
    check_eq("sp_done",  32'(n_done), 32'd1);
    check_eq("sp_idle",  32'(busy),   32'd0);

    // 3x3 frame with ready toggling: stalls must hold x/y.
    clear_rec();
    x_max = 10'd2;
    y_max = 10'd2;
    pulse_start();
    run(60, 1, 1);
    check_eq("tg_count", 32'(xq.size()), 32'd9);
    check_raster("tg", 3);
    check_eq("tg_stall", 32'(stall_bad), 32'd0);
    check_eq("tg_done",  32'(n_done),    32'd1);
    check_eq("tg_err",   32'(err),       32'd0);

    // Outstanding limit: no results, exactly MAX_OUT transfers.
    clear_rec();
    x_max = 10'd15;
    y_max = 10'd0;
    pulse_start();
    run(20, 0, 0);
    check_eq("lim_count", 32'(xq.size()),   32'd8);
    check_eq("lim_cv",    32'(coord_valid), 32'd0);
    check_eq("lim_x",     32'(x),           32'd8);
    // start while busy is ignored
    pulse_start();
    check_eq("lim_start_ign_x", 32'(x),    32'd8);
    check_eq("lim_busy",        32'(busy), 32'd1);
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    clear_rec();
    run(10, 0, 0);
    check_eq("lim_one_more", 32'(xq.size()), 32'd1);
    check_eq("lim_one_x",    32'(xq.size() > 0 ? xq[0] : -1), 32'd8);
    pulse_abort();
    check_eq("lim_abort_busy", 32'(busy), 32'd0);
    check_eq("lim_abort_done", 32'(done), 32'd0);

    // Abort after 5 transfers of a 10x10 frame.
    clear_rec();
    x_max = 10'd9;
    y_max = 10'd9;
    coord_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 5; i++) tick();
    check_eq("ab_x5", 32'(x), 32'd5);
    pulse_abort();
    check_eq("ab_busy", 32'(busy),        32'd0);
    check_eq("ab_cv",   32'(coord_valid), 32'd0);
    check_eq("ab_done", 32'(done),        32'd0);
    run(6, 0, 0);
    check_eq("ab_no_done", 32'(n_done),    32'd0);
    check_eq("ab_no_xfer", 32'(xq.size()), 32'd0);
    pulse_start();
    check_eq("ab_re_x",  32'(x),           32'd0);
    check_eq("ab_re_y",  32'(y),           32'd0);
    check_eq("ab_re_cv", 32'(coord_valid), 32'd1);
    pulse_abort();

    // Stray result in IDLE sets sticky err; next start clears it.
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    check_eq("err_set", 32'(err), 32'd1);
    tick();
    check_eq("err_sticky", 32'(err), 32'd1);
    coord_ready = 1'b0;
    pulse_start();
    check_eq("err_clr", 32'(err), 32'd0);
    pulse_abort();

    // Asynchronous reset mid-frame discards it without done.
    clear_rec();
    x_max = 10'd9;
    y_max = 10'd9;
    pulse_start();
    run(3, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar_busy", 32'(busy),        32'd0);
    check_eq("ar_cv",   32'(coord_valid), 32'd0);
    check_eq("ar_x",    32'(x),           32'd0);
    tick();
    rst = 1'b0;
    clear_rec();
    run(8, 0, 0);
    check_eq("ar_no_done", 32'(n_done),    32'd0);
    check_eq("ar_no_xfer", 32'(xq.size()), 32'd0);

`ifdef PIXEL_SEQ_LOOP_EN
    // Loop mode: frame restarts from (0,0) after done without a start.
    loop  = 1'b1;
    x_max = 10'd1;
    y_max = 10'd0;
    pulse_start();
    sh1      = 1'b0;
    got_done = 1'b0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      coord_ready = 1'b1;
      res_valid   = sh1;
      xf1         = coord_valid;
      tick();
      sh1 = xf1;
      if (done) got_done = 1'b1;
    end
    res_valid = 1'b0;
    check_eq("lp_done",   32'(got_done),    32'd1);
    check_eq("lp_cv",     32'(coord_valid), 32'd1);
    check_eq("lp_x",      32'(x),           32'd0);
    check_eq("lp_y",      32'(y),           32'd0);
    check_eq("lp_busy",   32'(busy),        32'd1);
    loop = 1'b0;
    clear_rec();
    run(30, 0, 1);
    check_eq("lp2_count", 32'(xq.size()), 32'd2);
    check_eq("lp2_done",  32'(n_done),    32'd1);
    check_eq("lp2_idle",  32'(busy),      32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
